seq_alu: RTL and testbench

- Clocked, parametrised successor to the datapath ALU.
- Same opcode map, with a WIDTH-parametrised datapath.
- Multiply (shift-add) and divide (restoring) are iterative multi-cycle operations instead of single-cycle combinational logic.
- Start/busy/done handshake, divide-by-zero and illegal-opcode flags, and registered outputs; it sits between the register-file read stage and writeback.

---
 rtl/seq_alu.sv | 151 +++++++++++++++
 tb/tb_seq_alu.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Clocked ALU with single-cycle add/sub/logic ops and iterative shift-add multiply
// and restoring divide, behind a start/busy/done handshake with registered results.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       con,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] r0,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             illegal
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h4;
    localparam logic [3:0] OP_DIV  = 4'h8;
    localparam logic [3:0] OP_AND  = 4'hC;
    localparam logic [3:0] OP_OR   = 4'hE;
    localparam logic [3:0] OP_ADD2 = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;   // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opb;   // multiplicand or divisor

    // one shift-add multiply iteration
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    // one restoring divide iteration
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] step_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opb};
        div_ok    = ~div_diff[WIDTH];
        rem_next  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_next  = {rem_next, acc[WIDTH-2:0], div_ok};

        step_next = (state == MUL) ? mul_next : div_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            out      <= '0;
            r0       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_zero <= 1'b0;
                        illegal  <= 1'b0;
                        case (con)
                            OP_ADD, OP_ADD2: begin
                                out  <= in1 + in2;
                                done <= 1'b1;
                            end
                            OP_SUB: begin
                                out  <= in1 - in2;
                                done <= 1'b1;
                            end
                            OP_AND: begin
                                out  <= in1 & in2;
                                done <= 1'b1;
                            end
                            OP_OR: begin
                                out  <= in1 | in2;
                                done <= 1'b1;
                            end
                            OP_MUL: begin
                                acc   <= {{WIDTH{1'b0}}, in2};
                                opb   <= in1;
                                cnt   <= CW'(WIDTH - 1);
                                busy  <= 1'b1;
                                state <= MUL;
                            end
                            OP_DIV: begin
                                if (in2 == '0) begin
                                    out      <= '1;
                                    r0       <= in1;
                                    div_zero <= 1'b1;
                                    done     <= 1'b1;
                                end else begin
                                    acc   <= {{WIDTH{1'b0}}, in1};
                                    opb   <= in2;
                                    cnt   <= CW'(WIDTH - 1);
                                    busy  <= 1'b1;
                                    state <= DIV;
                                end
                            end
                            default: begin
                                illegal <= 1'b1;
                                done    <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL, DIV: begin
                    acc <= step_next;
                    cnt <= cnt - 1'b1;
                    // last iteration edge publishes the result directly from the step logic
                    if (cnt == '0) begin
                        out   <= step_next[WIDTH-1:0];
                        r0    <= step_next[2*WIDTH-1:WIDTH];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=16: inputs driven and outputs
// sampled on the falling edge, results checked against hand-computed values.
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  con;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [15:0] out;
    logic [15:0] r0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .con(con), .in1(in1), .in2(in2),
        .out(out), .r0(r0), .busy(busy), .done(done), .div_zero(div_zero), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic s, input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
        start = s; con = c; in1 = a; in2 = b;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(1'b0, 4'h0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        checks++; if ({out, r0} !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", {out, r0}); end
        checks++; if ({busy, done, div_zero, illegal} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {busy, done, div_zero, illegal}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add;
        drive(1'b1, 4'h1, 16'hFFFF, 16'h0002);
        @(negedge clk);
        drive(1'b0, 4'h0, 16'h0, 16'h0);
        checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL add_hs got done,busy=%b want 10", {done, busy}); end
        checks++; if (out !== 16'h0001) begin errors++; $display("FAIL add_out got %h want 0001", out); end
        checks++; if (r0 !== 16'h0000) begin errors++; $display("FAIL add_r0 got %h want 0000", r0); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_pulse got done=%b want 0", done); end
    endtask

    task automatic test_mul;
        int n;
        int overlap;
        drive(1'b1, 4'h4, 16'h1234, 16'h5678);
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL mul_busy got busy,done=%b want 10", {busy, done}); end
        drive(1'b1, 4'h1, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        drive(1'b0, 4'h0, 16'h0, 16'h0);
        n = 2;
        overlap = 0;
        while (!done && n < 40) begin
            if (busy === 1'b0) overlap++;
            @(negedge clk);
            n++;
            if (done && busy) overlap++;
        end
        checks++; if (n !== 17) begin errors++; $display("FAIL mul_latency got %0d want 17", n); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL mul_busy_window got %0d bad cycles want 0", overlap); end
        checks++; if ({r0, out} !== 32'h0626_0060) begin errors++; $display("FAIL mul_result got %h want 06260060", {r0, out}); end
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL mul_after got done,busy=%b want 00", {done, busy}); end
    endtask

    task automatic test_div;
        int n;
        drive(1'b1, 4'h8, 16'd100, 16'd7);
        @(negedge clk);
        drive(1'b0, 4'h0, 16'h0, 16'h0);
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 17) begin errors++; $display("FAIL div_latency got %0d want 17", n); end
        checks++; if (out !== 16'd14) begin errors++; $display("FAIL div_quot got %0d want 14", out); end
        checks++; if (r0 !== 16'd2) begin errors++; $display("FAIL div_rem got %0d want 2", r0); end
        drive(1'b1, 4'h8, 16'h00AB, 16'h0000);
        @(negedge clk);
        drive(1'b0, 4'h0, 16'h0, 16'h0);
        checks++; if ({done, busy, div_zero, illegal} !== 4'b1010) begin errors++; $display("FAIL divz_flags got %b want 1010", {done, busy, div_zero, illegal}); end
        checks++; if ({out, r0} !== {16'hFFFF, 16'h00AB}) begin errors++; $display("FAIL divz_data got %h want ffff00ab", {out, r0}); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n;
        drive(1'b1, 4'h2, 16'd3, 16'd5);
        @(negedge clk);
        checks++; if ({done, out, r0} !== {1'b1, 16'hFFFE, 16'h00AB}) begin errors++; $display("FAIL sub got done=%b out=%h r0=%h want 1 fffe 00ab", done, out, r0); end
        drive(1'b1, 4'hC, 16'hF0F0, 16'h0FF0);
        @(negedge clk);
        checks++; if ({done, out} !== {1'b1, 16'h00F0}) begin errors++; $display("FAIL b2b_and got done=%b out=%h want 1 00f0", done, out); end
        drive(1'b1, 4'hE, 16'hF0F0, 16'h0FF0);
        @(negedge clk);
        checks++; if ({done, out} !== {1'b1, 16'hFFF0}) begin errors++; $display("FAIL b2b_or got done=%b out=%h want 1 fff0", done, out); end
        drive(1'b1, 4'hF, 16'h1234, 16'h1111);
        @(negedge clk);
        checks++; if ({done, out, r0} !== {1'b1, 16'h2345, 16'h00AB}) begin errors++; $display("FAIL b2b_add got done=%b out=%h r0=%h want 1 2345 00ab", done, out, r0); end
        drive(1'b1, 4'h4, 16'd3, 16'd5);
        @(negedge clk);
        drive(1'b0, 4'h0, 16'h0, 16'h0);
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_mul_accept got busy,done=%b want 10", {busy, done}); end
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 17) begin errors++; $display("FAIL b2b_mul_latency got %0d want 17", n); end
        checks++; if ({r0, out} !== 32'h0000_000F) begin errors++; $display("FAIL b2b_mul_result got %h want 0000000f", {r0, out}); end
        @(negedge clk);
    endtask

    task automatic test_illegal;
        drive(1'b1, 4'hD, 16'h5555, 16'hAAAA);
        @(negedge clk);
        drive(1'b0, 4'h0, 16'h0, 16'h0);
        checks++; if ({done, illegal, div_zero, busy} !== 4'b1100) begin errors++; $display("FAIL illegal_flags got %b want 1100", {done, illegal, div_zero, busy}); end
        checks++; if ({out, r0} !== 32'h000F_0000) begin errors++; $display("FAIL illegal_data got %h want 000f0000", {out, r0}); end
        @(negedge clk);
        checks++; if ({done, illegal} !== 2'b01) begin errors++; $display("FAIL illegal_hold got done,illegal=%b want 01", {done, illegal}); end
    endtask

    task automatic test_reset_abort;
        int seen;
        drive(1'b1, 4'h8, 16'd100, 16'd7);
        @(negedge clk);
        drive(1'b0, 4'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({out, r0} !== 32'h0) begin errors++; $display("FAIL abort_data got %h want 0", {out, r0}); end
        checks++; if ({busy, done, div_zero, illegal} !== 4'b0) begin errors++; $display("FAIL abort_flags got %b want 0000", {busy, done, div_zero, illegal}); end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", seen); end
        drive(1'b1, 4'h1, 16'd2, 16'd3);
        @(negedge clk);
        drive(1'b0, 4'h0, 16'h0, 16'h0);
        checks++; if ({done, out, r0} !== {1'b1, 16'd5, 16'd0}) begin errors++; $display("FAIL post_reset_add got done=%b out=%h r0=%h want 1 0005 0000", done, out, r0); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_mul;
        test_div;
        test_back_to_back;
        test_illegal;
        test_reset_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
